// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature-map readers.
package cnn_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} win_rd_state_e;

    // Number of whole windows along one axis, with no padding.
    function automatic int unsigned out_dim(input int unsigned img,
                                            input int unsigned k,
                                            input int unsigned stride);
        return (img - k) / stride + 1;
    endfunction

endpackage

// File: rtl/cnn_counter.sv
// Wrapping loop counter; pulse_o marks an enabled wrap and feeds the next level.
module cnn_counter #(
    parameter int unsigned MAX_P = 1,
    parameter int unsigned W_P   = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           en_i,
    output logic [W_P-1:0] cnt_o,
    output logic           at_max_o,
    output logic           pulse_o
);

    localparam logic [W_P-1:0] MAX_C = W_P'(MAX_P);

    logic [W_P-1:0] cnt_q;
    logic [W_P-1:0] cnt_d;

    assign at_max_o = (cnt_q == MAX_C);
    assign pulse_o  = en_i & at_max_o;
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = at_max_o ? '0 : cnt_q + W_P'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cnn_window_reader.sv
// Walks every KxK window of the feature map at the given stride and streams
// one read address per accepted beat, flagging window and frame ends.
module cnn_window_reader
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W_P  = 8,
    parameter int unsigned IMG_H_P  = 8,
    parameter int unsigned K_P      = 3,
    parameter int unsigned STRIDE_P = 1
) (
    input  logic                                              clk_i,
    input  logic                                              reset_n_i,
    input  logic                                              start_i,
    input  logic                                              ready_i,
    output logic                                              valid_o,
    output logic [$clog2(IMG_W_P*IMG_H_P)-1:0]                addr_o,
    output logic                                              win_last_o,
    output logic                                              frame_last_o,
    output logic [$clog2(out_dim(IMG_H_P, K_P, STRIDE_P))-1:0] oy_o,
    output logic [$clog2(out_dim(IMG_W_P, K_P, STRIDE_P))-1:0] ox_o,
    output logic                                              busy_o,
    output logic                                              done_o
);

    localparam int unsigned OUT_W  = out_dim(IMG_W_P, K_P, STRIDE_P);
    localparam int unsigned OUT_H  = out_dim(IMG_H_P, K_P, STRIDE_P);
    localparam int unsigned ADDR_W = $clog2(IMG_W_P*IMG_H_P);
    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned KW     = $clog2(K_P);
    localparam int unsigned OXW    = $clog2(OUT_W);
    localparam int unsigned OYW    = $clog2(OUT_H);
    localparam logic [AW1-1:0] S_C = AW1'(STRIDE_P);
    localparam logic [AW1-1:0] W_C = AW1'(IMG_W_P);

    win_rd_state_e state_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;

    logic [KW-1:0]  kx_q, ky_q;
    logic [OXW-1:0] ox_q;
    logic [OYW-1:0] oy_q;
    logic kx_max, ky_max, ox_max, oy_max;
    logic kx_pulse, ky_pulse, ox_pulse, oy_pulse;
    logic fire;
    logic ctr_rst;
    logic [AW1-1:0] row_w, col_w;

    assign fire    = valid_q & ready_i;
    // Counters clear on reset and on the accepted start, so a new frame begins at (0,0).
    assign ctr_rst = ~reset_n_i | ((state_q == IDLE) & start_i);

    cnn_counter #(.MAX_P(K_P - 1), .W_P(KW)) u_kx (
        .clk_i(clk_i), .reset_i(ctr_rst), .en_i(fire),
        .cnt_o(kx_q), .at_max_o(kx_max), .pulse_o(kx_pulse));

    cnn_counter #(.MAX_P(K_P - 1), .W_P(KW)) u_ky (
        .clk_i(clk_i), .reset_i(ctr_rst), .en_i(kx_pulse),
        .cnt_o(ky_q), .at_max_o(ky_max), .pulse_o(ky_pulse));

    cnn_counter #(.MAX_P(OUT_W - 1), .W_P(OXW)) u_ox (
        .clk_i(clk_i), .reset_i(ctr_rst), .en_i(ky_pulse),
        .cnt_o(ox_q), .at_max_o(ox_max), .pulse_o(ox_pulse));

    cnn_counter #(.MAX_P(OUT_H - 1), .W_P(OYW)) u_oy (
        .clk_i(clk_i), .reset_i(ctr_rst), .en_i(ox_pulse),
        .cnt_o(oy_q), .at_max_o(oy_max), .pulse_o(oy_pulse));

    always_comb begin
        row_w = AW1'(oy_q) * S_C + AW1'(ky_q);
        col_w = AW1'(ox_q) * S_C + AW1'(kx_q);
    end

    assign addr_o       = ADDR_W'(row_w * W_C + col_w);
    assign win_last_o   = kx_max & ky_max;
    assign frame_last_o = kx_max & ky_max & ox_max & oy_max;
    assign ox_o         = ox_q;
    assign oy_o         = oy_q;
    assign valid_o      = valid_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

    // oy_pulse is exactly "final beat accepted".
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (oy_pulse) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_reader.sv
// Randomised-backpressure bench for cnn_window_reader against a nested-loop window model.
module tb_cnn_window_reader;

    typedef struct {
        int addr;
        int wl;
        int fl;
        int ox;
        int oy;
    } exp_t;

    logic       clk;
    logic       rst_n_r [2];
    logic       start_r [2];
    logic       ready_r [2];
    logic       valid_w [2];
    logic [3:0] addr_w  [2];
    logic       wl_w    [2];
    logic       fl_w    [2];
    logic       oy_w    [2];
    logic       ox_w    [2];
    logic       busy_w  [2];
    logic       done_w  [2];

    int n_checks;
    int n_pass;
    exp_t exp_q[$];

    cnn_window_reader #(.IMG_W_P(4), .IMG_H_P(4), .K_P(2), .STRIDE_P(2)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n_r[0]), .start_i(start_r[0]), .ready_i(ready_r[0]),
        .valid_o(valid_w[0]), .addr_o(addr_w[0]), .win_last_o(wl_w[0]),
        .frame_last_o(fl_w[0]), .oy_o(oy_w[0]), .ox_o(ox_w[0]),
        .busy_o(busy_w[0]), .done_o(done_w[0]));

    cnn_window_reader #(.IMG_W_P(4), .IMG_H_P(4), .K_P(3), .STRIDE_P(1)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n_r[1]), .start_i(start_r[1]), .ready_i(ready_r[1]),
        .valid_o(valid_w[1]), .addr_o(addr_w[1]), .win_last_o(wl_w[1]),
        .frame_last_o(fl_w[1]), .oy_o(oy_w[1]), .ox_o(ox_w[1]),
        .busy_o(busy_w[1]), .done_o(done_w[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: every window in raster order, taps in raster order within the window.
    task automatic build_model(input int s);
        int kk, ss, iw, ih, ow, oh;
        exp_t e;
        kk = (s == 0) ? 2 : 3;
        ss = (s == 0) ? 2 : 1;
        iw = 4;
        ih = 4;
        ow = (iw - kk) / ss + 1;
        oh = (ih - kk) / ss + 1;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < kk; ky++)
                    for (int kx = 0; kx < kk; kx++) begin
                        e.addr = (oy * ss + ky) * iw + ox * ss + kx;
                        e.wl   = (kx == kk - 1 && ky == kk - 1) ? 1 : 0;
                        e.fl   = (e.wl == 1 && ox == ow - 1 && oy == oh - 1) ? 1 : 0;
                        e.ox   = ox;
                        e.oy   = oy;
                        exp_q.push_back(e);
                    end
    endtask

    task automatic pulse_start(input int s);
        @(posedge clk); #1;
        start_r[s] = 1'b1;
        ready_r[s] = 1'b0;
        @(posedge clk); #1;
        start_r[s] = 1'b0;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_frame(input int s, input int mode, input bit restart);
        int total, beats, cyc, last_cyc, rdy;
        bit finished;
        int pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        build_model(s);
        total = exp_q.size();
        beats = 0;
        cyc = 0;
        last_cyc = -1;
        finished = 1'b0;
        pulse_start(s);
        while (!finished && cyc < 400) begin
            case (mode)
                0: rdy = 1;
                1: rdy = pat[cyc % 4];
                default: rdy = int'($urandom_range(0, 1));
            endcase
            ready_r[s] = rdy[0];
            start_r[s] = restart && (cyc == 3 || cyc == 10);
            @(negedge clk);
            check("valid_run", valid_w[s], 1);
            check("busy_run", busy_w[s], 1);
            check("done_mid", done_w[s], 0);
            if (exp_q.size() > 0) begin
                check("addr", addr_w[s], exp_q[0].addr);
                check("win_last", wl_w[s], exp_q[0].wl);
                check("frame_last", fl_w[s], exp_q[0].fl);
                check("ox", ox_w[s], exp_q[0].ox);
                check("oy", oy_w[s], exp_q[0].oy);
            end
            if (rdy == 1) begin
                beats++;
                if (exp_q.size() > 0) begin
                    if (exp_q[0].fl == 1) begin
                        finished = 1'b1;
                        last_cyc = cyc;
                    end
                    exp_q.delete(0);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_r[s] = 1'b0;
        ready_r[s] = $urandom_range(0, 1) == 1;
        if (!finished) check("frame_timeout", 0, 1);
        check("beat_count", beats, total);
        if (mode == 0) check("last_beat_cycle", last_cyc, total - 1);
        @(negedge clk);
        check("done_pulse", done_w[s], 1);
        check("valid_in_done", valid_w[s], 0);
        check("busy_in_done", busy_w[s], 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clear", done_w[s], 0);
        check("busy_idle", busy_w[s], 0);
        check("valid_idle", valid_w[s], 0);
        @(posedge clk); #1;
        ready_r[s] = 1'b0;
        @(negedge clk);
        check("no_queued_start", valid_w[s], 0);
    endtask

    task automatic abort_frame(input int s);
        build_model(s);
        pulse_start(s);
        for (int i = 0; i < 6; i++) begin
            ready_r[s] = 1'b1;
            @(negedge clk);
            check("abort_pre_addr", addr_w[s], exp_q[0].addr);
            exp_q.delete(0);
            @(posedge clk); #1;
        end
        rst_n_r[s] = 1'b0;
        @(posedge clk); #1;
        rst_n_r[s] = 1'b1;
        @(negedge clk);
        check("abort_valid", valid_w[s], 0);
        check("abort_busy", busy_w[s], 0);
        check("abort_done", done_w[s], 0);
        check("abort_addr", addr_w[s], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done_w[s], 0);
        end
        ready_r[s] = 1'b0;
        run_frame(s, 0, 1'b0);
    endtask

    task automatic reset_vs_start(input int s);
        @(posedge clk); #1;
        rst_n_r[s] = 1'b0;
        start_r[s] = 1'b1;
        @(posedge clk); #1;
        rst_n_r[s] = 1'b1;
        start_r[s] = 1'b0;
        @(negedge clk);
        check("rst_start_valid", valid_w[s], 0);
        check("rst_start_busy", busy_w[s], 0);
        @(negedge clk);
        check("rst_start_stay_idle", valid_w[s], 0);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        for (int s = 0; s < 2; s++) begin
            rst_n_r[s] = 1'b0;
            start_r[s] = 1'b0;
            ready_r[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n_r[0] = 1'b1;
        rst_n_r[1] = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_valid", valid_w[s], 0);
            check("rst_busy", busy_w[s], 0);
            check("rst_done", done_w[s], 0);
            check("rst_addr", addr_w[s], 0);
            check("rst_ox", ox_w[s], 0);
            check("rst_oy", oy_w[s], 0);
        end

        run_frame(0, 0, 1'b0);
        run_frame(1, 0, 1'b0);
        run_frame(0, 1, 1'b0);
        run_frame(0, 0, 1'b1);
        abort_frame(0);
        reset_vs_start(0);
        reset_vs_start(1);
        for (int r = 0; r < 3; r++) begin
            run_frame(0, 2, r == 1);
            run_frame(1, 2, r == 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cnn_window_reader.md
Name: cnn_window_reader

Overview:
- Read-side address sequencer for a feature-map buffer.
- After a start pulse, walks every K×K convolution window of an IMG_H_P×IMG_W_P map at stride STRIDE_P and emits one buffer read address per beat.
- Output is a valid/ready stream.
- Consumes the iteration structure that the write side builds. Sits between the feature-map RAM and the MAC array; flags tell the MAC when a window and the frame complete.

Parameters:
- IMG_W_P, 8, feature-map width in pixels.
- IMG_H_P, 8, feature-map height in pixels.
- K_P, 3, kernel edge (window is K_P×K_P). Must be ≥2.
- STRIDE_P, 1, window step in both directions. Must be ≥1.
- Derived: OUT_W = (IMG_W_P-K_P)/STRIDE_P+1 and OUT_H likewise, both required ≥2. ADDR_W = $clog2(IMG_W_P*IMG_H_P).

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- start_i  in  1  begin a frame scan; sampled only in IDLE.
- ready_i  in  1  downstream accepts the current beat.
- valid_o  out  1  addr_o and flags are valid.
- addr_o  out  ADDR_W  linear read address = (oy*S+ky)*IMG_W_P + ox*S + kx.
- win_last_o  out  1  current beat is tap (K-1,K-1) of its window.
- frame_last_o  out  1  current beat is the final beat of the frame.
- oy_o  out  $clog2(OUT_H)  output row of the current window.
- ox_o  out  $clog2(OUT_W)  output column of the current window.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse after the frame completes.

Behaviour:
- Reset (reset_n_i=0 at a clock edge):
  - State goes to IDLE.
  - All counters (kx, ky, ox, oy) go to 0.
  - valid_o, busy_o, done_o go to 0.
  - addr_o, oy_o, ox_o read 0.
- FSM states:
  - IDLE: start_i=1 → RUN. Counters are cleared on the same edge.
  - RUN: valid_o=1 every cycle. A beat fires when valid_o & ready_i. Fire with frame_last_o → DONE.
  - DONE: done_o=1 and valid_o=0 for exactly one cycle, then → IDLE.
- Latency: first beat has valid_o=1 in the cycle after start_i is sampled. Back-to-back beats proceed at 1/cycle while ready_i=1.
- Counter advance, only on fire:
  - Order is kx fastest, then ky, ox, oy.
  - Each counter wraps to 0 at its max (K-1, K-1, OUT_W-1, OUT_H-1). Its wrap is the enable of the next level.
  - No partial windows and no edge padding.
- Stall: while valid_o=1 and ready_i=0, addr_o, the flags, oy_o and ox_o hold exactly. valid_o never drops mid-frame.
- Address arithmetic:
  - addr_o is combinational from the registered counters.
  - Products are computed at ADDR_W+1 bits and truncated to ADDR_W; the maximum legal value fits by construction.
- Flag rules:
  - win_last_o = (kx==K-1)&&(ky==K-1).
  - frame_last_o = win_last_o && ox==OUT_W-1 && oy==OUT_H-1.
- start_i in RUN or DONE is ignored. It is not queued.
- Reset mid-frame: aborts immediately with no done_o. The next start begins from window (0,0).
- start_i and reset_n_i=0 together: reset wins.
- ready_i while valid_o=0 has no effect.

Decomposition:
- Shared package cnn_pkg holds:
  - typedef enum {IDLE, RUN, DONE} win_rd_state_e.
  - A function computing OUT_W/OUT_H from (img, k, stride).
- Sub-module: four chained cnn_counter instances, one per loop level.
  - en of each level is fire for kx, then the pulse_o of the level below.
  - Counter reset_i = ~reset_n_i | (IDLE & start_i), which adapts to its active-high reset and gives the clear on start.
  - frame_last comes from the oy counter pulse condition, qualified by the lower-level wrap conditions.

Test Plan:
- W=H=4, K=2, S=2, ready_i=1, one start pulse → exactly 16 beats with addr 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
  - win_last_o on beats 4, 8, 12, 16; frame_last_o only on beat 16.
  - done_o one cycle after beat 16; busy_o low in the cycle after done_o.
- W=H=4, K=3, S=1 → 36 beats.
  - Window (oy=0, ox=1) addresses are 1,2,3,5,6,7,9,10,11.
  - Final beat addr=15 with frame_last_o=1.
- Backpressure with ready_i toggled 1,0,0,1,… (K=2, S=2 config) → addr_o/flags are stable during every ready_i=0 cycle, and the addr sequence is identical to the first test.
- start_i re-pulsed on cycles 3 and 10 of a running frame → beat count is still 16 and exactly one done_o.
- reset_n_i=0 for one cycle after beat 6 → valid_o=0 next cycle and no done_o. A new start then gives first addr=0.
- start_i and reset_n_i=0 asserted together in IDLE → stays IDLE, valid_o=0.
